// File: rtl/vm_link_pkg.sv
// Shared definitions for the multislope ADC result link: frame geometry, field map,
// command prefix, error codes and the FSM state encodings used by vm_frame_rx and
// vm_cmd_tx.
package vm_link_pkg;

    localparam int unsigned FRAME_BYTES = 6;
    localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;

    // Run-up length command byte is {CMD_PREFIX, selector}.
    localparam logic [3:0] CMD_PREFIX = 4'h5;

    // Byte offsets from the start of the frame; b0 arrives first.
    localparam int unsigned OFS_RUNUP_CNT_HI = 0;
    localparam int unsigned OFS_RUNUP_CNT_LO = 1;
    localparam int unsigned OFS_RUNUP_SET_HI = 2;
    localparam int unsigned OFS_RUNUP_SET_LO = 3;
    localparam int unsigned OFS_RUNDOWN_HI   = 4;
    localparam int unsigned OFS_RUNDOWN_LO   = 5;

    // Bit positions in the assembled frame word, b0 in the top byte.
    localparam int unsigned BIT_B47           = FRAME_BITS - 1 - 8 * OFS_RUNUP_CNT_HI;
    localparam int unsigned BIT_RUNUP_CNT_MSB = BIT_B47 - 1;
    localparam int unsigned BIT_RUNUP_CNT_LSB = FRAME_BITS - 8 * (OFS_RUNUP_CNT_LO + 1);
    localparam int unsigned BIT_RD_SIGN       = FRAME_BITS - 1 - 8 * OFS_RUNUP_SET_HI;
    localparam int unsigned BIT_RUNUP_SET_MSB = BIT_RD_SIGN - 1;
    localparam int unsigned BIT_RUNUP_SET_LSB = FRAME_BITS - 8 * (OFS_RUNUP_SET_LO + 1);
    localparam int unsigned BIT_RUNDOWN_MSB   = FRAME_BITS - 1 - 8 * OFS_RUNDOWN_HI;
    localparam int unsigned BIT_RUNDOWN_LSB   = FRAME_BITS - 8 * (OFS_RUNDOWN_LO + 1);

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_GAP   = 2'd1,
        ERR_B47   = 2'd2,
        ERR_RANGE = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_COLLECT,
        F_CHECK
    } frame_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_WAIT
    } cmd_state_t;

endpackage

// File: rtl/vm_cmd_tx.sv
// Run-up length command sender. Latches one command byte on cmd_req and hands it to
// a UART transmitter with a start/busy handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cmd_req      one-cycle request, ignored unless idle
//   cmd_sel      run-up selector, sent unmodified in the low nibble
//   tx_busy      transmitter busy
//   tx_start     held high until tx_busy is seen
//   tx_data      command byte
//   cmd_pending  high from acceptance until the transmitter drops busy
module vm_cmd_tx
    import vm_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [3:0] cmd_sel,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cmd_pending
);

    cmd_state_t state_q, state_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tx_start    = 1'b0;
        cmd_pending = 1'b1;
        unique case (state_q)
            C_IDLE: begin
                cmd_pending = 1'b0;
                if (cmd_req) begin
                    data_d  = {CMD_PREFIX, cmd_sel};
                    state_d = C_START;
                end
            end
            C_START: begin
                tx_start = 1'b1;
                if (tx_busy) begin
                    state_d = C_WAIT;
                end
            end
            C_WAIT: begin
                if (!tx_busy) begin
                    state_d = C_IDLE;
                end
            end
            default: begin
                cmd_pending = 1'b0;
                state_d     = C_IDLE;
            end
        endcase
    end

    assign tx_data = data_q;

endmodule

// File: rtl/vm_frame_rx.sv
// Host-side receiver for the multislope ADC result link. Reassembles 6-byte frames
// from a UART byte stream, validates them, publishes the fields and the signed
// run-up balance, and sends run-up length commands through vm_cmd_tx.
// Ports:
//   mclk, rst            clock, asynchronous active-high reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   cmd_req, cmd_sel     run-up command request and selector
//   tx_busy, tx_start,   transmitter handshake and command byte
//   tx_data, cmd_pending
//   frame_valid          one-cycle strobe, field outputs updated
//   frame_err, err_code  one-cycle strobe for a discarded frame and its reason
//   runup_cnt, runup_set, rundown_sign, rundown_cnt, balance   decoded fields
module vm_frame_rx
    import vm_link_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cmd_req,
    input  logic [3:0]  cmd_sel,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        cmd_pending,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [14:0] runup_cnt,
    output logic [14:0] runup_set,
    output logic        rundown_sign,
    output logic [15:0] rundown_cnt,
    output logic [16:0] balance
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(FRAME_BYTES - 1);

    frame_state_t          state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;

    logic      pass, fail;
    err_code_t fail_code;

    logic        frame_valid_q, frame_err_q;
    err_code_t   err_code_q;
    logic [14:0] runup_cnt_q, runup_set_q;
    logic        rundown_sign_q;
    logic [15:0] rundown_cnt_q;
    logic [16:0] balance_q;

    // Field view of the assembled frame; only meaningful in F_CHECK.
    logic        f_b47;
    logic [14:0] f_runup_cnt, f_runup_set;
    logic        f_sign;
    logic [15:0] f_rundown;
    logic [16:0] f_balance;

    assign f_b47       = shreg_q[BIT_B47];
    assign f_runup_cnt = shreg_q[BIT_RUNUP_CNT_MSB:BIT_RUNUP_CNT_LSB];
    assign f_sign      = shreg_q[BIT_RD_SIGN];
    assign f_runup_set = shreg_q[BIT_RUNUP_SET_MSB:BIT_RUNUP_SET_LSB];
    assign f_rundown   = shreg_q[BIT_RUNDOWN_MSB:BIT_RUNDOWN_LSB];
    // Both operands zero-extended; |result| <= 32767 so 17 bits never overflow.
    assign f_balance   = {1'b0, f_runup_cnt, 1'b0} - {2'b00, f_runup_set};

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q        <= F_IDLE;
            idx_q          <= 3'd0;
            gap_q          <= '0;
            shreg_q        <= '0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            err_code_q     <= ERR_NONE;
            runup_cnt_q    <= 15'd0;
            runup_set_q    <= 15'd0;
            rundown_sign_q <= 1'b0;
            rundown_cnt_q  <= 16'd0;
            balance_q      <= 17'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            shreg_q       <= shreg_d;
            frame_valid_q <= pass;
            frame_err_q   <= fail;
            if (fail) begin
                err_code_q <= fail_code;
            end
            if (pass) begin
                runup_cnt_q    <= f_runup_cnt;
                runup_set_q    <= f_runup_set;
                rundown_sign_q <= f_sign;
                rundown_cnt_q  <= f_rundown;
                balance_q      <= f_balance;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        shreg_d   = shreg_q;
        pass      = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        unique case (state_q)
            F_IDLE: begin
                gap_d = '0;
                if (rx_valid) begin
                    shreg_d = {shreg_q[FRAME_BITS-9:0], rx_data};
                    idx_d   = 3'd1;
                    state_d = F_COLLECT;
                end
            end
            F_COLLECT: begin
                if (rx_valid) begin
                    // A byte on the timeout cycle still counts.
                    shreg_d = {shreg_q[FRAME_BITS-9:0], rx_data};
                    gap_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = F_CHECK;
                    end
                end else if (gap_q == GAP_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_GAP;
                    state_d   = F_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            F_CHECK: begin
                gap_d = '0;
                if (f_b47) begin
                    fail      = 1'b1;
                    fail_code = ERR_B47;
                end else if (f_runup_cnt > f_runup_set) begin
                    fail      = 1'b1;
                    fail_code = ERR_RANGE;
                end else begin
                    pass = 1'b1;
                end
                // A byte here is b0 of the next frame; the check above has already
                // consumed the old word, so it can shift straight in.
                if (rx_valid) begin
                    shreg_d = {shreg_q[FRAME_BITS-9:0], rx_data};
                    idx_d   = 3'd1;
                    state_d = F_COLLECT;
                end else begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    vm_cmd_tx u_cmd_tx (
        .clk         (mclk),
        .rst         (rst),
        .cmd_req     (cmd_req),
        .cmd_sel     (cmd_sel),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .cmd_pending (cmd_pending)
    );

    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign err_code     = err_code_q;
    assign runup_cnt    = runup_cnt_q;
    assign runup_set    = runup_set_q;
    assign rundown_sign = rundown_sign_q;
    assign rundown_cnt  = rundown_cnt_q;
    assign balance      = balance_q;

endmodule

// File: tb/tb_vm_frame_rx.sv
// Self-checking bench for vm_frame_rx: frames are pushed to an expectation queue as
// they are sent and popped when frame_valid/frame_err appears.
module tb_vm_frame_rx;

    localparam int unsigned GAP = 4000;

    logic        mclk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_req;
    logic [3:0]  cmd_sel;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        cmd_pending;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [14:0] runup_cnt;
    logic [14:0] runup_set;
    logic        rundown_sign;
    logic [15:0] rundown_cnt;
    logic [16:0] balance;

    vm_frame_rx #(.GAP_CYCLES(GAP)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_req      (cmd_req),
        .cmd_sel      (cmd_sel),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .cmd_pending  (cmd_pending),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .runup_cnt    (runup_cnt),
        .runup_set    (runup_set),
        .rundown_sign (rundown_sign),
        .rundown_cnt  (rundown_cnt),
        .balance      (balance)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [14:0] rc;
        logic [14:0] rs;
        logic        sign;
        logic [15:0] rd;
        logic [16:0] bal;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_good;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t zero_exp();
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.rc     = '0;
        e.rs     = '0;
        e.sign   = 1'b0;
        e.rd     = '0;
        e.bal    = '0;
        return e;
    endfunction

    // Reference decode of one frame word (b0 in the top byte).
    function automatic void push_frame(input logic [47:0] f);
        exp_t e;
        int   rc, rs, bal;
        rc       = int'(f[46:32]);
        rs       = int'(f[30:16]);
        e        = last_good;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        if (f[47]) begin
            e.is_err = 1'b1;
            e.code   = 2'd2;
        end else if (rc > rs) begin
            e.is_err = 1'b1;
            e.code   = 2'd3;
        end else begin
            bal       = 2 * rc - rs;
            e.rc      = rc[14:0];
            e.rs      = rs[14:0];
            e.sign    = f[31];
            e.rd      = f[15:0];
            e.bal     = bal[16:0];
            last_good = e;
        end
        exp_q.push_back(e);
    endfunction

    function automatic void push_gap();
        exp_t e;
        e        = last_good;
        e.is_err = 1'b1;
        e.code   = 2'd1;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, input int gap);
        push_frame(f);
        for (int i = 0; i < 6; i++) begin
            send_byte(f[47-8*i -: 8]);
            if (i < 5) idle(gap);
        end
    endtask

    // Waits for the next strobe, pops the expectation and compares it.
    // lat_exp <= 0 skips the latency comparison.
    task automatic expect_result(input string name, input int lat_exp, input int budget);
        exp_t e;
        int   k;
        logic seen;
        seen = 1'b0;
        for (k = 1; k <= budget; k++) begin
            @(negedge mclk);
            if (frame_valid || frame_err) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s strobe: none within %0d cycles", name, budget);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s queue: strobe with no expectation", name);
            return;
        end
        e = exp_q.pop_front();
        total++;
        if ({frame_valid, frame_err} !== {~e.is_err, e.is_err}) begin
            bad++;
            $display("FAIL %s kind: got valid=%0b err=%0b want valid=%0b err=%0b",
                     name, frame_valid, frame_err, ~e.is_err, e.is_err);
        end
        if (e.is_err) begin
            total++;
            if (err_code !== e.code) begin
                bad++;
                $display("FAIL %s err_code: got %0d want %0d", name, err_code, e.code);
            end
        end
        if (lat_exp > 0) begin
            total++;
            if (k !== lat_exp) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, k, lat_exp);
            end
        end
        total++;
        if (runup_cnt !== e.rc) begin
            bad++;
            $display("FAIL %s runup_cnt: got %0d want %0d", name, runup_cnt, e.rc);
        end
        total++;
        if (runup_set !== e.rs) begin
            bad++;
            $display("FAIL %s runup_set: got %0d want %0d", name, runup_set, e.rs);
        end
        total++;
        if (rundown_sign !== e.sign) begin
            bad++;
            $display("FAIL %s rundown_sign: got %0b want %0b", name, rundown_sign, e.sign);
        end
        total++;
        if (rundown_cnt !== e.rd) begin
            bad++;
            $display("FAIL %s rundown_cnt: got %0d want %0d", name, rundown_cnt, e.rd);
        end
        total++;
        if (balance !== e.bal) begin
            bad++;
            $display("FAIL %s balance: got %h want %h", name, balance, e.bal);
        end
        @(negedge mclk);
        total++;
        if ({frame_valid, frame_err} !== 2'b00) begin
            bad++;
            $display("FAIL %s one_cycle: got valid=%0b err=%0b want 0 0",
                     name, frame_valid, frame_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [77:0] outs;
        outs = {tx_start, tx_data, cmd_pending, frame_valid, frame_err, err_code, runup_cnt,
                runup_set, rundown_sign, rundown_cnt, balance};
        total++;
        if (outs !== 78'd0) begin
            bad++;
            $display("FAIL %s outputs: got %h want 0", name, outs);
        end
    endtask

    task automatic test_reset();
        @(negedge mclk);
        check_all_zero("reset");
    endtask

    task automatic test_basic();
        send_frame(48'h00C8_87CF_012C, 10);
        expect_result("basic", 2, 20);
        total++;
        if ($signed(balance) !== -17'sd1599) begin
            bad++;
            $display("FAIL basic_const balance: got %0d want -1599", $signed(balance));
        end
    endtask

    task automatic test_gap();
        logic [47:0] f;
        f = 48'h0011_2233_4455;
        for (int i = 0; i < 3; i++) begin
            send_byte(f[47-8*i -: 8]);
            if (i < 2) idle(10);
        end
        push_gap();
        expect_result("gap_timeout", GAP + 1, GAP + 20);
        send_frame(48'h0064_03E7_8001, 0);
        expect_result("after_gap", 2, 20);
        // Every byte lands on the last cycle before timeout; max positive balance.
        send_frame(48'h7FFF_FFFF_FFFF, GAP - 1);
        expect_result("gap_edge", 2, 20);
    endtask

    task automatic test_errors();
        send_frame(48'h80C8_87CF_012C, 2);
        expect_result("bit47", 2, 20);
        send_frame(48'h0258_0257_1234, 2);
        expect_result("range", 2, 20);
        send_frame(48'h8258_0257_1234, 0);
        expect_result("bit47_prec", 2, 20);
        send_frame(48'h0000_7FFF_0000, 1);
        expect_result("min_balance", 2, 20);
    endtask

    task automatic test_back_to_back();
        tick();
        fork
            begin
                send_frame(48'h0123_0FFF_ABCD, 0);
                send_frame(48'h0400_8400_00FF, 0);
            end
            begin
                expect_result("b2b_a", 8, 30);
                expect_result("b2b_b", -1, 30);
            end
        join
    endtask

    task automatic test_cmd();
        int starts;
        starts = 0;
        tick();
        for (int i = 0; i <= 50; i++) begin
            cmd_req = (i == 0) || (i == 10);
            cmd_sel = (i == 10) ? 4'd7 : 4'd3;
            tx_busy = (i >= 2) && (i < 42);
            @(negedge mclk);
            if (tx_start) starts++;
            if (i == 1 || i == 42 || i == 43) begin
                total++;
                if (cmd_pending !== (i != 43)) begin
                    bad++;
                    $display("FAIL cmd_pending@%0d: got %0b want %0b", i, cmd_pending, i != 43);
                end
            end
            if (i == 20) begin
                total++;
                if (tx_data !== 8'h53) begin
                    bad++;
                    $display("FAIL cmd_data: got %h want 53", tx_data);
                end
            end
            tick();
        end
        total++;
        if (starts !== 2) begin
            bad++;
            $display("FAIL cmd_start_len: got %0d want 2", starts);
        end
        // Out-of-range selector goes out unchanged.
        cmd_req = 1'b1;
        cmd_sel = 4'd12;
        tick();
        cmd_req = 1'b0;
        @(negedge mclk);
        total++;
        if ({tx_start, tx_data} !== {1'b1, 8'h5C}) begin
            bad++;
            $display("FAIL cmd_sel12: got start=%0b data=%h want 1 5c", tx_start, tx_data);
        end
        tick();
        tx_busy = 1'b1;
        idle(3);
        tx_busy = 1'b0;
        idle(3);
        total++;
        if ({tx_start, cmd_pending} !== 2'b00) begin
            bad++;
            $display("FAIL cmd_done: got start=%0b pending=%0b want 0 0", tx_start, cmd_pending);
        end
    endtask

    task automatic test_reset_mid();
        logic [47:0] f;
        int          strobes;
        f = 48'h00C8_87CF_012C;
        tick();
        cmd_req = 1'b1;
        cmd_sel = 4'd9;
        tick();
        cmd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(f[47-8*i -: 8]);
            idle(2);
        end
        rx_data  = f[7:0];
        rx_data  = f[15:8];
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge mclk);
        check_all_zero("reset_mid");
        tick();
        rst      = 1'b0;
        rx_valid = 1'b0;
        last_good = zero_exp();
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            if (frame_valid || frame_err) strobes++;
        end
        total++;
        if (strobes !== 0) begin
            bad++;
            $display("FAIL reset_strobe: got %0d want 0", strobes);
        end
        check_all_zero("reset_hold");
        tick();
        send_frame(f, 3);
        expect_result("after_reset", 2, 20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_req   = 1'b0;
        cmd_sel   = 4'd0;
        tx_busy   = 1'b0;
        last_good = zero_exp();
        repeat (3) @(posedge mclk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_errors();
        test_back_to_back();
        test_cmd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
